// File: rtl/fsm_burst.sv
// Burst request/acknowledge controller: one request moves len+1 beats, each closed by an ack.
// Latency: req -> read/write on the sampling edge; final ack -> idle/done on that edge.
// Backpressure: slave stalls by withholding ack; TIMEOUT quiet busy cycles abort with err.
module fsm_burst #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [LEN_W-1:0] len,
  input  logic             ack,
  output logic             idle,
  output logic             read,
  output logic             write,
  output logic [LEN_W-1:0] beat,
  output logic             done,
  output logic             err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // State and datapath registers; reset abandons any burst without pulsing done/err.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state: start on req, count beats on ack, abort after TIMEOUT quiet busy cycles.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    len_d   = len_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = we ? S_WRITE : S_READ;
          len_d   = len;
          beat_d  = '0;
          tcnt_d  = '0;
        end
      end
      S_READ, S_WRITE: begin
        if (ack) begin
          // An ack on the would-be timeout edge still counts as progress.
          tcnt_d = '0;
          if (beat_q == len_q) begin
            state_d = S_IDLE;
            beat_d  = '0;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end else if (tcnt_q == TCNT_LAST) begin
          state_d = S_IDLE;
          beat_d  = '0;
          tcnt_d  = '0;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
        tcnt_d  = '0;
      end
    endcase
  end

  // Moore outputs decoded straight from registers.
  always_comb begin
    idle  = (state_q == S_IDLE);
    read  = (state_q == S_READ);
    write = (state_q == S_WRITE);
    beat  = beat_q;
    done  = done_q;
    err   = err_q;
  end

endmodule
